// File: rtl/alu_pkg.sv
// Shared definitions for the execute controller: opcodes, FSM states, default widths.
package alu_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic [2:0] {
      OP_ADD  = 3'b000,
      OP_SUB  = 3'b001,
      OP_AND  = 3'b010,
      OP_OR   = 3'b011,
      OP_XOR  = 3'b100,
      OP_NOTA = 3'b101,
      OP_SHL1 = 3'b110,
      OP_MOVA = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_EXEC  = 2'd2,
      ST_WRITE = 2'd3
   } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus carry/zero (flag outputs exist only with ALU_EXEC_FLAGS_EN).
// Zero latency, no flow control.
module alu_core
   import alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [2:0]        opcode,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result
`ifdef ALU_EXEC_FLAGS_EN
   ,
   output logic              carry,
   output logic              zero
`endif
);

   always_comb begin
      result = '0;
      case (opcode_e'(opcode))
         OP_ADD:  result = a + b;
         OP_SUB:  result = a - b;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOTA: result = ~a;
         OP_SHL1: result = {a[DATA_W-2:0], 1'b0};
         OP_MOVA: result = a;
         default: result = '0;
      endcase
   end

`ifdef ALU_EXEC_FLAGS_EN
   logic [DATA_W:0] sum_ext;

   // SUB carry is the borrow, i.e. a < b unsigned.
   always_comb begin
      sum_ext = {1'b0, a} + {1'b0, b};
      carry   = 1'b0;
      case (opcode_e'(opcode))
         OP_ADD:  carry = sum_ext[DATA_W];
         OP_SUB:  carry = (a < b);
         OP_SHL1: carry = a[DATA_W-1];
         default: carry = 1'b0;
      endcase
   end

   assign zero = (result == '0);
`endif

endmodule

// File: rtl/alu_exec_ctrl.sv
// Read-execute-writeback controller for the 8x16 register file; 4 cycles per instruction,
// instr_ready high only in IDLE. Flags built only when ALU_EXEC_FLAGS_EN is defined, else tied 0.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        opcode,
   input  logic [ADDR_W-1:0] dst,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   output logic [ADDR_W-1:0] rd_addr_a,
   output logic [ADDR_W-1:0] rd_addr_b,
   input  logic [DATA_W-1:0] d_out_a,
   input  logic [DATA_W-1:0] d_out_b,
   output logic              wr,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] d_in,
   output logic              done,
   output logic              flag_z,
   output logic              flag_c
);

   state_e              state_q, state_d;
   logic [2:0]          opc_q, opc_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [ADDR_W-1:0]   srca_q, srca_d;
   logic [ADDR_W-1:0]   srcb_q, srcb_d;
   logic [DATA_W-1:0]   opa_q, opa_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic [DATA_W-1:0]   res_q, res_d;
   logic [DATA_W-1:0]   alu_res;

   always_comb begin
      state_d = state_q;
      opc_d   = opc_q;
      dst_d   = dst_q;
      srca_d  = srca_q;
      srcb_d  = srcb_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               opc_d   = opcode;
               dst_d   = dst;
               srca_d  = src_a;
               srcb_d  = src_b;
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            opa_d   = d_out_a;
            opb_d   = d_out_b;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            res_d   = alu_res;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         opc_q   <= '0;
         dst_q   <= '0;
         srca_q  <= '0;
         srcb_q  <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
         dst_q   <= dst_d;
         srca_q  <= srca_d;
         srcb_q  <= srcb_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
      end
   end

   // Outputs decode straight from state, so an async reset drops wr/done at once.
   assign instr_ready = (state_q == ST_IDLE);
   assign rd_addr_a   = srca_q;
   assign rd_addr_b   = srcb_q;
   assign wr          = (state_q == ST_WRITE);
   assign done        = (state_q == ST_WRITE);
   assign wr_addr     = dst_q;
   assign d_in        = res_q;

`ifdef ALU_EXEC_FLAGS_EN
   logic alu_carry, alu_zero;
   logic carry_q, carry_d, zero_q, zero_d;
   logic flag_c_q, flag_c_d, flag_z_q, flag_z_d;

   alu_core #(.DATA_W(DATA_W)) u_alu_core (
      .opcode (opc_q),
      .a      (opa_q),
      .b      (opb_q),
      .result (alu_res),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   // Flags captured in EXEC, made visible only once the write retires.
   always_comb begin
      carry_d  = carry_q;
      zero_d   = zero_q;
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      if (state_q == ST_EXEC) begin
         carry_d = alu_carry;
         zero_d  = alu_zero;
      end
      if (state_q == ST_WRITE) begin
         flag_c_d = carry_q;
         flag_z_d = zero_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
      end
   end

   assign flag_z = flag_z_q;
   assign flag_c = flag_c_q;
`else
   alu_core #(.DATA_W(DATA_W)) u_alu_core (
      .opcode (opc_q),
      .a      (opa_q),
      .b      (opb_q),
      .result (alu_res)
   );

   assign flag_z = 1'b0;
   assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural register file and reference ALU model.
module tb_alu_exec_ctrl;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        instr_valid = 1'b0;
   logic        instr_ready;
   logic [2:0]  opcode = '0;
   logic [2:0]  dst = '0, src_a = '0, src_b = '0;
   logic [2:0]  rd_addr_a, rd_addr_b;
   logic [15:0] d_out_a, d_out_b;
   logic        wr, done, flag_z, flag_c;
   logic [2:0]  wr_addr;
   logic [15:0] d_in;

   alu_exec_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .dst         (dst),
      .src_a       (src_a),
      .src_b       (src_b),
      .rd_addr_a   (rd_addr_a),
      .rd_addr_b   (rd_addr_b),
      .d_out_a     (d_out_a),
      .d_out_b     (d_out_b),
      .wr          (wr),
      .wr_addr     (wr_addr),
      .d_in        (d_in),
      .done        (done),
      .flag_z      (flag_z),
      .flag_c      (flag_c)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural register file; bench pokes go through the same process as DUT writes.
   logic [15:0] rf [8];
   logic        poke_en = 1'b0;
   logic [2:0]  poke_addr = '0;
   logic [15:0] poke_dat = '0;
   assign d_out_a = rf[rd_addr_a];
   assign d_out_b = rf[rd_addr_b];
   always @(posedge clk) begin
      if (wr) rf[wr_addr] <= d_in;
      else if (poke_en) rf[poke_addr] <= poke_dat;
   end

   logic [15:0] mregs [8];

   typedef struct {
      logic [2:0]  dst;
      logic [15:0] dat;
      logic        z;
      logic        c;
      int          wcyc;
   } exp_t;
   exp_t sb[$];
   int last_acc = -100;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [15:0] a16, input logic [15:0] b16,
                                 output logic [15:0] r, output logic c);
      int a, b, s;
      a = int'(a16);
      b = int'(b16);
      s = 0;
      c = 1'b0;
      case (op)
         3'd0: begin s = a + b; c = (s > 65535); end
         3'd1: begin s = a - b; c = (a < b); end
         3'd2: s = a & b;
         3'd3: s = a | b;
         3'd4: s = a ^ b;
         3'd5: s = ~a;
         3'd6: begin s = a * 2; c = (a >= 32768); end
         default: s = a;
      endcase
      r = s[15:0];
   endfunction

   task automatic poke(input logic [2:0] addr, input logic [15:0] val);
      @(negedge clk);
      poke_en = 1'b1; poke_addr = addr; poke_dat = val;
      mregs[addr] = val;
      @(negedge clk);
      poke_en = 1'b0;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!instr_ready) chk("ready_timeout", instr_ready, 1);
   endtask

   // Called at a negedge; returns at the negedge of cycle 4 relative to the accept.
   task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] sa,
                        input logic [2:0] sb_i, input bit hold, input bit chk_gap);
      logic [15:0] r;
      logic c, z;
      wait_ready();
      instr_valid = 1'b1; opcode = op; dst = d; src_a = sa; src_b = sb_i;
      model(op, mregs[sa], mregs[sb_i], r, c);
      z = (r == 16'h0);
`ifndef ALU_EXEC_FLAGS_EN
      z = 1'b0;
      c = 1'b0;
`endif
      mregs[d] = r;
      sb.push_back('{d, r, z, c, cyc + 3});
      if (chk_gap) chk("accept_spacing", cyc - last_acc, 4);
      last_acc = cyc;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (!hold) begin
            // Junk while busy; the controller must ignore it.
            instr_valid = 1'($urandom); opcode = 3'($urandom); dst = 3'($urandom);
            src_a = 3'($urandom); src_b = 3'($urandom);
         end
         chk("ready_busy", instr_ready, 0);
         @(negedge clk);
      end
      chk("ready_back", instr_ready, 1);
      if (!hold) instr_valid = 1'b0;
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n) begin
            chk("done_eq_wr", done, wr);
            if (wr) begin
               if (sb.size() == 0) chk("unexpected_wr", wr, 0);
               else begin
                  e = sb.pop_front();
                  chk("wr_addr", wr_addr, e.dst);
                  chk("d_in", d_in, e.dat);
                  chk("wr_cycle", cyc, e.wcyc);
                  @(negedge clk);
                  chk("flag_z", flag_z, e.z);
                  chk("flag_c", flag_c, e.c);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, instr_ready, 1);
      chk({tag, "_wr"}, wr, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_wr_addr"}, wr_addr, 0);
      chk({tag, "_d_in"}, d_in, 0);
      chk({tag, "_rd_a"}, rd_addr_a, 0);
      chk({tag, "_rd_b"}, rd_addr_b, 0);
      chk({tag, "_flag_z"}, flag_z, 0);
      chk({tag, "_flag_c"}, flag_c, 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 8; i++) mregs[i] = 16'h0;
      // Register file initialised while reset is held.
      for (int i = 0; i < 8; i++) poke(3'(i), 16'($urandom));
      poke(3'd0, 16'hABCD);
      poke(3'd1, 16'h1234);
      poke(3'd5, 16'h8001);
      chk_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      issue(3'd0, 3'd2, 3'd0, 3'd1, 1'b0, 1'b0);   // ADD  -> BE01
      issue(3'd1, 3'd3, 3'd1, 3'd0, 1'b0, 1'b0);   // SUB  -> 6667, borrow
      issue(3'd4, 3'd4, 3'd0, 3'd0, 1'b0, 1'b0);   // XOR  -> 0000, zero
      issue(3'd6, 3'd5, 3'd5, 3'd3, 1'b0, 1'b0);   // SHL1 -> 0002, carry, dst==src
      issue(3'd7, 3'd6, 3'd2, 3'd1, 1'b1, 1'b0);   // back-to-back pair
      issue(3'd3, 3'd7, 3'd6, 3'd4, 1'b0, 1'b1);

      // Reset during EXEC: the in-flight ADD must never be written.
      wait_ready();
      instr_valid = 1'b1; opcode = 3'd0; dst = 3'd1; src_a = 3'd0; src_b = 3'd0;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midreset_wr_low", wr, 0);
      end
      reset_n = 1'b1;
      for (int i = 0; i < 5; i++) @(negedge clk);

      poke(3'd6, 16'hFFFF);
      poke(3'd7, 16'h0001);
      issue(3'd0, 3'd6, 3'd6, 3'd7, 1'b0, 1'b0);   // FFFF+0001 wraps
      issue(3'd7, 3'd0, 3'd1, 3'd2, 1'b0, 1'b0);   // MOV of r1 shows it survived the aborted write

      for (int k = 0; k < 40; k++) begin
         bit h;
         h = (k != 39) && ($urandom_range(0, 2) == 0);
         issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), h, 1'b0);
         if (h) begin
            issue(3'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'b0, 1'b1);
            k++;
         end
      end

      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", sb.size(), 0);
      for (int i = 0; i < 3; i++) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
